x1_input_conditioner: RTL and testbench

- Sits directly upstream of the Moore sequence machine.
- Takes the raw, asynchronous `ui_in[0]` pad level and produces a clean, debounced `x1` level for the machine.
  - Two-flop synchronizer, then a counter-based debounce state machine.
  - Registered rise/fall pulses on `x1`.
  - Saturating count of rejected glitches, for bring-up visibility on spare `uo_out` pins.

---
 rtl/x1_cond_pkg.sv | 14 +
 rtl/x1_input_conditioner_sync2.sv | 25 ++
 rtl/x1_input_conditioner.sv | 146 ++++++++++++++
 tb/tb_x1_input_conditioner.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/x1_cond_pkg.sv
// Shared types and defaults for the x1 input conditioner.
package x1_cond_pkg;

  typedef enum logic [1:0] {
    LO_STABLE = 2'd0,
    CHK_HI    = 2'd1,
    HI_STABLE = 2'd2,
    CHK_LO    = 2'd3
  } x1_cond_state_t;

  localparam int X1_DEBOUNCE_DEFAULT = 4;
  localparam int X1_GLITCH_W_DEFAULT = 4;

endpackage

// File: rtl/x1_input_conditioner_sync2.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_r;
  logic s2_r;

  // Shift the pad level through two flops to settle metastability.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= d;
      s2_r <= s1_r;
    end
  end

  assign q = s2_r;

endmodule

// File: rtl/x1_input_conditioner.sv
// Debounces the raw ui_in[0] pad level into x1 for the Moore sequence machine.
// At chip level: uo_out[4] = x1_rise, uo_out[7:5] = glitch_cnt[2:0].
// Optional feature macro: X1_COND_EDGE_PULSE_EN builds the x1_rise/x1_fall
// edge flops; without it both ports are tied to 0.
module x1_input_conditioner
  import x1_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = X1_DEBOUNCE_DEFAULT,
  parameter int GLITCH_W        = X1_GLITCH_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                raw_in,
  output logic                x1,
  output logic                x1_rise,
  output logic                x1_fall,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = {GLITCH_W{1'b1}};

  if ((DEBOUNCE_CYCLES < 1) || (DEBOUNCE_CYCLES > 255)) begin : g_bad_debounce
    $error("x1_input_conditioner: DEBOUNCE_CYCLES must be in 1..255");
  end

  logic               s2;
  x1_cond_state_t     state_r;
  x1_cond_state_t     state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic [GLITCH_W-1:0] glitch_r;
  logic [GLITCH_W-1:0] glitch_nxt_s;
  logic               glitch_inc_s;
  logic               x1_r;
  logic               x1_nxt_s;

  sync2 u_sync2 (
    .clk (clk),
    .rst (rst),
    .d   (raw_in),
    .q   (s2)
  );

  // Next-state, debounce count, glitch accounting and next x1 level.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    glitch_inc_s = 1'b0;
    case (state_r)
      LO_STABLE: begin
        if (s2) begin
          state_nxt_s = CHK_HI;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = LO_STABLE;
        end
      end
      CHK_HI: begin
        if (!s2) begin
          state_nxt_s  = LO_STABLE;
          glitch_inc_s = 1'b1;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = HI_STABLE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      HI_STABLE: begin
        if (!s2) begin
          state_nxt_s = CHK_LO;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = HI_STABLE;
        end
      end
      CHK_LO: begin
        if (s2) begin
          state_nxt_s  = HI_STABLE;
          glitch_inc_s = 1'b1;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = LO_STABLE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = LO_STABLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase

    // x1 is high while stable-high or still checking a possible fall.
    x1_nxt_s = (state_nxt_s == HI_STABLE) || (state_nxt_s == CHK_LO);

    // Saturate rather than wrap so a noisy pad never reads as quiet.
    if (glitch_inc_s && (glitch_r != GLITCH_MAX)) begin
      glitch_nxt_s = glitch_r + GLITCH_W'(1);
    end else begin
      glitch_nxt_s = glitch_r;
    end
  end

  // State, counters and the registered x1 level.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= LO_STABLE;
      cnt_r    <= CNT_ZERO;
      glitch_r <= {GLITCH_W{1'b0}};
      x1_r     <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      glitch_r <= glitch_nxt_s;
      x1_r     <= x1_nxt_s;
    end
  end

`ifdef X1_COND_EDGE_PULSE_EN
  logic rise_r;
  logic fall_r;

  // One-cycle pulses aligned with the first cycle of the new x1 level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      rise_r <= x1_nxt_s & ~x1_r;
      fall_r <= ~x1_nxt_s & x1_r;
    end
  end

  assign x1_rise = rise_r;
  assign x1_fall = fall_r;
`else
  assign x1_rise = 1'b0;
  assign x1_fall = 1'b0;
`endif

  assign x1         = x1_r;
  assign glitch_cnt = glitch_r;

endmodule

// File: tb/tb_x1_input_conditioner.sv
// Directed bench for x1_input_conditioner (DEBOUNCE_CYCLES=4, GLITCH_W=4).
// Pulse expectations follow whether X1_COND_EDGE_PULSE_EN is defined.
module tb_x1_input_conditioner;

`ifdef X1_COND_EDGE_PULSE_EN
  localparam bit PULSE_EN = 1'b1;
`else
  localparam bit PULSE_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       raw_in;
  logic       x1;
  logic       x1_rise;
  logic       x1_fall;
  logic [3:0] glitch_cnt;

  int tests;
  int fails;

  x1_input_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .GLITCH_W        (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .raw_in     (raw_in),
    .x1         (x1),
    .x1_rise    (x1_rise),
    .x1_fall    (x1_fall),
    .glitch_cnt (glitch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit before driving/sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    raw_in = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    raw_in = 1'b1;
    repeat (3) tick();
    tests++; if (x1 !== 1'b0) begin fails++; $display("FAIL reset_x1: got %b want 0", x1); end
    tests++; if (glitch_cnt !== 4'd0) begin fails++; $display("FAIL reset_glitch: got %0d want 0", glitch_cnt); end
    tests++; if ({x1_rise, x1_fall} !== 2'b00) begin fails++; $display("FAIL reset_pulses: got %b want 00", {x1_rise, x1_fall}); end
    rst = 1'b0;
    // Edges r..r+5 leave x1 low; edge r+6 raises it.
    for (int i = 0; i < 6; i++) begin
      tick();
      tests++; if (x1 !== 1'b0) begin fails++; $display("FAIL reset_release_early edge r+%0d: got %b want 0", i, x1); end
    end
    tick();
    tests++; if (x1 !== 1'b1) begin fails++; $display("FAIL reset_release_x1: got %b want 1", x1); end
    tests++; if (x1_rise !== PULSE_EN) begin fails++; $display("FAIL reset_release_rise: got %b want %b", x1_rise, PULSE_EN); end
    tick();
    tests++; if (x1_rise !== 1'b0) begin fails++; $display("FAIL reset_rise_width: got %b want 0", x1_rise); end
  endtask

  task automatic test_clean_rise_fall();
    int rise_seen;
    int fall_seen;
    rise_seen = 0;
    fall_seen = 0;
    do_reset();
    repeat (4) tick();
    raw_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      rise_seen += int'(x1_rise); fall_seen += int'(x1_fall);
      tests++; if (x1 !== 1'b0) begin fails++; $display("FAIL rise_early edge k+%0d: got %b want 0", i, x1); end
    end
    tick();
    rise_seen += int'(x1_rise); fall_seen += int'(x1_fall);
    tests++; if (x1 !== 1'b1) begin fails++; $display("FAIL rise_x1 edge k+6: got %b want 1", x1); end
    tests++; if (x1_rise !== PULSE_EN) begin fails++; $display("FAIL rise_pulse: got %b want %b", x1_rise, PULSE_EN); end
    for (int i = 0; i < 8; i++) begin
      tick();
      rise_seen += int'(x1_rise); fall_seen += int'(x1_fall);
    end
    raw_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      rise_seen += int'(x1_rise); fall_seen += int'(x1_fall);
      tests++; if (x1 !== 1'b1) begin fails++; $display("FAIL fall_early edge k+%0d: got %b want 1", i, x1); end
    end
    tick();
    rise_seen += int'(x1_rise); fall_seen += int'(x1_fall);
    tests++; if (x1 !== 1'b0) begin fails++; $display("FAIL fall_x1 edge k+6: got %b want 0", x1); end
    tests++; if (x1_fall !== PULSE_EN) begin fails++; $display("FAIL fall_pulse: got %b want %b", x1_fall, PULSE_EN); end
    repeat (6) begin
      tick();
      rise_seen += int'(x1_rise); fall_seen += int'(x1_fall);
    end
    tests++; if (rise_seen != int'(PULSE_EN)) begin fails++; $display("FAIL rise_count: got %0d want %0d", rise_seen, int'(PULSE_EN)); end
    tests++; if (fall_seen != int'(PULSE_EN)) begin fails++; $display("FAIL fall_count: got %0d want %0d", fall_seen, int'(PULSE_EN)); end
    tests++; if (glitch_cnt !== 4'd0) begin fails++; $display("FAIL clean_glitch: got %0d want 0", glitch_cnt); end
  endtask

  task automatic test_bounce();
    bit saw_high;
    saw_high = 1'b0;
    do_reset();
    raw_in = 1'b1; repeat (3) begin tick(); saw_high |= x1; end
    raw_in = 1'b0; repeat (2) begin tick(); saw_high |= x1; end
    raw_in = 1'b1; repeat (3) begin tick(); saw_high |= x1; end
    raw_in = 1'b0; repeat (10) begin tick(); saw_high |= x1; end
    tests++; if (saw_high !== 1'b0) begin fails++; $display("FAIL bounce_x1: got %b want 0", saw_high); end
    tests++; if (glitch_cnt !== 4'd2) begin fails++; $display("FAIL bounce_glitch: got %0d want 2", glitch_cnt); end
  endtask

  task automatic test_min_pulse();
    bit saw_high;
    // Four s2 cycles from the detect cycle: rejected.
    saw_high = 1'b0;
    do_reset();
    raw_in = 1'b1; repeat (4) begin tick(); saw_high |= x1; end
    raw_in = 1'b0; repeat (12) begin tick(); saw_high |= x1; end
    tests++; if (saw_high !== 1'b0) begin fails++; $display("FAIL pulse4_x1: got %b want 0", saw_high); end
    tests++; if (glitch_cnt !== 4'd1) begin fails++; $display("FAIL pulse4_glitch: got %0d want 1", glitch_cnt); end
    // Five s2 cycles: accepted, then a clean fall back to low.
    saw_high = 1'b0;
    do_reset();
    raw_in = 1'b1; repeat (5) begin tick(); saw_high |= x1; end
    raw_in = 1'b0; repeat (14) begin tick(); saw_high |= x1; end
    tests++; if (saw_high !== 1'b1) begin fails++; $display("FAIL pulse5_x1: got %b want 1", saw_high); end
    tests++; if (x1 !== 1'b0) begin fails++; $display("FAIL pulse5_settle: got %b want 0", x1); end
    tests++; if (glitch_cnt !== 4'd0) begin fails++; $display("FAIL pulse5_glitch: got %0d want 0", glitch_cnt); end
  endtask

  task automatic test_saturation();
    bit saw_high;
    saw_high = 1'b0;
    do_reset();
    for (int p = 0; p < 20; p++) begin
      raw_in = 1'b1; repeat (2) begin tick(); saw_high |= x1; end
      raw_in = 1'b0; repeat (4) begin tick(); saw_high |= x1; end
      if (p == 14) begin
        tests++; if (glitch_cnt !== 4'd15) begin fails++; $display("FAIL sat_at15: got %0d want 15", glitch_cnt); end
      end
    end
    repeat (4) tick();
    tests++; if (glitch_cnt !== 4'd15) begin fails++; $display("FAIL sat_hold: got %0d want 15", glitch_cnt); end
    tests++; if (saw_high !== 1'b0) begin fails++; $display("FAIL sat_x1: got %b want 0", saw_high); end
    // A saturated counter must not block a normal accepted rise.
    raw_in = 1'b1;
    repeat (6) tick();
    tests++; if (x1 !== 1'b0) begin fails++; $display("FAIL sat_rise_early: got %b want 0", x1); end
    tick();
    tests++; if (x1 !== 1'b1) begin fails++; $display("FAIL sat_rise: got %b want 1", x1); end
    tests++; if (glitch_cnt !== 4'd15) begin fails++; $display("FAIL sat_after_rise: got %0d want 15", glitch_cnt); end
    raw_in = 1'b0;
  endtask

  task automatic test_mid_check_reset();
    do_reset();
    // Leave one glitch recorded so the reset has something to clear.
    raw_in = 1'b1; repeat (2) tick();
    raw_in = 1'b0; repeat (6) tick();
    tests++; if (glitch_cnt !== 4'd1) begin fails++; $display("FAIL midrst_pre_glitch: got %0d want 1", glitch_cnt); end
    raw_in = 1'b1;
    repeat (5) tick();   // CHK_HI entered at k+2; now in its third cycle
    rst = 1'b1;
    tick();
    tests++; if (x1 !== 1'b0) begin fails++; $display("FAIL midrst_x1: got %b want 0", x1); end
    tests++; if (glitch_cnt !== 4'd0) begin fails++; $display("FAIL midrst_glitch: got %0d want 0", glitch_cnt); end
    tests++; if ({x1_rise, x1_fall} !== 2'b00) begin fails++; $display("FAIL midrst_pulses: got %b want 00", {x1_rise, x1_fall}); end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      tests++; if (x1 !== 1'b0) begin fails++; $display("FAIL midrst_early edge r+%0d: got %b want 0", i, x1); end
    end
    tick();
    tests++; if (x1 !== 1'b1) begin fails++; $display("FAIL midrst_rise: got %b want 1", x1); end
    tests++; if (x1_rise !== PULSE_EN) begin fails++; $display("FAIL midrst_rise_pulse: got %b want %b", x1_rise, PULSE_EN); end
    raw_in = 1'b0;
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    rst    = 1'b1;
    raw_in = 1'b0;
    test_reset();
    test_clean_rise_fall();
    test_bounce();
    test_min_pulse();
    test_saturation();
    test_mid_check_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
